// File: rtl/ram_access_master.sv
// Initiator for the word-wide dual-port data RAM: byte/half/word loads and stores, sub-word stores via RMW.
// Optional macro RAM_ACC_MISALIGN_TRAP_EN: misaligned half/word accesses take the error path instead of being masked.
module ram_access_master #(
    parameter int AW     = 12,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic              req_we_i,
    input  logic [1:0]        req_size_i,
    input  logic              req_unsigned_i,
    input  logic [ADDR_W-1:0] req_addr_i,
    input  logic [31:0]       req_wdata_i,
    output logic              resp_valid_o,
    output logic [31:0]       resp_rdata_o,
    output logic              resp_err_o,
    output logic              ram_wen_o,
    output logic [AW-1:0]     ram_w_addr_o,
    output logic [31:0]       ram_w_data_o,
    output logic              ram_ren_o,
    output logic [AW-1:0]     ram_r_addr_o,
    input  logic [31:0]       ram_r_data_i
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LD_RD  = 3'd1;
    localparam logic [2:0] S_LD_RSP = 3'd2;
    localparam logic [2:0] S_ST_WR  = 3'd3;
    localparam logic [2:0] S_RMW_RD = 3'd4;
    localparam logic [2:0] S_RMW_WR = 3'd5;
    localparam logic [2:0] S_ERR    = 3'd6;

    logic [2:0]    r_state;
    logic [1:0]    r_size;
    logic          r_unsigned;
    logic [AW-1:0] r_waddr;
    logic [1:0]    r_lane;
    logic [31:0]   r_wdata;

    logic          w_size_bad;
    logic          w_out_of_range;
    logic          w_misaligned;
    logic          w_err;
    logic [1:0]    w_lane;
    logic [4:0]    w_shamt;
    logic [31:0]   w_rshift;
    logic [31:0]   w_mask;
    logic [31:0]   w_merged;
    logic [31:0]   w_load_ext;
    logic          w_busy;

    // Request decode (input side only; feeds the latch, never the outputs)
    always_comb begin
        w_size_bad     = (req_size_i == 2'b11);
        w_out_of_range = ((req_addr_i >> (AW + 2)) != '0);
`ifdef RAM_ACC_MISALIGN_TRAP_EN
        w_misaligned   = ((req_size_i == 2'b01) && req_addr_i[0]) ||
                         ((req_size_i == 2'b10) && (req_addr_i[1:0] != 2'b00));
`else
        w_misaligned   = 1'b0;
`endif
        w_err = w_size_bad || w_out_of_range || w_misaligned;
        case (req_size_i)
            2'b00:   w_lane = req_addr_i[1:0];
            2'b01:   w_lane = {req_addr_i[1], 1'b0};
            default: w_lane = 2'b00;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_size     <= '0;
            r_unsigned <= 1'b0;
            r_waddr    <= '0;
            r_lane     <= '0;
            r_wdata    <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (req_valid_i) begin
                        r_size     <= req_size_i;
                        r_unsigned <= req_unsigned_i;
                        r_waddr    <= req_addr_i[AW+1:2];
                        r_lane     <= w_lane;
                        r_wdata    <= req_wdata_i;
                        if (w_err)
                            r_state <= S_ERR;
                        else if (!req_we_i)
                            r_state <= S_LD_RD;
                        else if (req_size_i == 2'b10)
                            r_state <= S_ST_WR;
                        else
                            r_state <= S_RMW_RD;
                    end
                end
                S_LD_RD:  r_state <= S_LD_RSP;
                S_RMW_RD: r_state <= S_RMW_WR;
                default:  r_state <= S_IDLE;
            endcase
        end
    end

    // Lane extraction for loads and lane merge for read-modify-write
    always_comb begin
        w_shamt  = {r_lane, 3'b000};
        w_rshift = ram_r_data_i >> w_shamt;
        w_mask   = ((r_size == 2'b00) ? 32'h0000_00FF : 32'h0000_FFFF) << w_shamt;
        w_merged = (ram_r_data_i & ~w_mask) | ((r_wdata << w_shamt) & w_mask);
        case (r_size)
            2'b00:   w_load_ext = r_unsigned ? {24'h0, w_rshift[7:0]}
                                             : {{24{w_rshift[7]}}, w_rshift[7:0]};
            2'b01:   w_load_ext = r_unsigned ? {16'h0, w_rshift[15:0]}
                                             : {{16{w_rshift[15]}}, w_rshift[15:0]};
            default: w_load_ext = ram_r_data_i;
        endcase
    end

    always_comb begin
        w_busy       = (r_state != S_IDLE);
        req_ready_o  = (r_state == S_IDLE);
        ram_ren_o    = (r_state == S_LD_RD) || (r_state == S_RMW_RD);
        ram_wen_o    = (r_state == S_ST_WR) || (r_state == S_RMW_WR);
        ram_w_addr_o = w_busy ? r_waddr : '0;
        ram_r_addr_o = w_busy ? r_waddr : '0;
        ram_w_data_o = '0;
        if (r_state == S_ST_WR)
            ram_w_data_o = r_wdata;
        else if (r_state == S_RMW_WR)
            ram_w_data_o = w_merged;
        resp_valid_o = (r_state == S_LD_RSP) || (r_state == S_ST_WR) ||
                       (r_state == S_RMW_WR) || (r_state == S_ERR);
        resp_err_o   = (r_state == S_ERR);
        resp_rdata_o = (r_state == S_LD_RSP) ? w_load_ext : '0;
    end

endmodule

// File: tb/tb_ram_access_master.sv
// Directed self-checking bench for ram_access_master with a behavioural 1-cycle-read dual-port RAM.
// Expectations follow RAM_ACC_MISALIGN_TRAP_EN when it is defined for the build.
module tb_ram_access_master;

    localparam int AW     = 12;
    localparam int ADDR_W = 32;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              req_valid_i = 1'b0;
    logic              req_ready_o;
    logic              req_we_i = 1'b0;
    logic [1:0]        req_size_i = 2'b00;
    logic              req_unsigned_i = 1'b0;
    logic [ADDR_W-1:0] req_addr_i = '0;
    logic [31:0]       req_wdata_i = '0;
    logic              resp_valid_o;
    logic [31:0]       resp_rdata_o;
    logic              resp_err_o;
    logic              ram_wen_o;
    logic [AW-1:0]     ram_w_addr_o;
    logic [31:0]       ram_w_data_o;
    logic              ram_ren_o;
    logic [AW-1:0]     ram_r_addr_o;
    logic [31:0]       ram_r_data_i;

    int n_cmp = 0;
    int n_bad = 0;

    int          t_lat;
    int          t_nw;
    int          t_nr;
    logic [31:0] t_rdata;
    logic        t_err;
    logic [31:0] t_waddr;
    logic [31:0] t_wdata;
    logic [31:0] t_raddr;

    ram_access_master #(.AW(AW), .ADDR_W(ADDR_W)) dut (
        .clk            (clk),
        .rst            (rst),
        .req_valid_i    (req_valid_i),
        .req_ready_o    (req_ready_o),
        .req_we_i       (req_we_i),
        .req_size_i     (req_size_i),
        .req_unsigned_i (req_unsigned_i),
        .req_addr_i     (req_addr_i),
        .req_wdata_i    (req_wdata_i),
        .resp_valid_o   (resp_valid_o),
        .resp_rdata_o   (resp_rdata_o),
        .resp_err_o     (resp_err_o),
        .ram_wen_o      (ram_wen_o),
        .ram_w_addr_o   (ram_w_addr_o),
        .ram_w_data_o   (ram_w_data_o),
        .ram_ren_o      (ram_ren_o),
        .ram_r_addr_o   (ram_r_addr_o),
        .ram_r_data_i   (ram_r_data_i)
    );

    always #5 clk = ~clk;

    // Dual-port RAM with registered read and write-to-read forwarding
    logic [31:0] mem [0:(1<<AW)-1];
    initial begin
        for (int unsigned i = 0; i < (1 << AW); i++) mem[i] = '0;
        ram_r_data_i = '0;
    end
    always @(posedge clk) begin
        if (ram_wen_o) mem[ram_w_addr_o] <= ram_w_data_o;
        if (ram_ren_o)
            ram_r_data_i <= (ram_wen_o && ram_w_addr_o == ram_r_addr_o) ? ram_w_data_o : mem[ram_r_addr_o];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic do_req(input logic we, input logic [1:0] size, input logic uns,
                          input logic [31:0] addr, input logic [31:0] wdata);
        bit done;
        @(negedge clk);
        check("ready_idle", {31'b0, req_ready_o}, 32'd1);
        req_we_i       = we;
        req_size_i     = size;
        req_unsigned_i = uns;
        req_addr_i     = addr;
        req_wdata_i    = wdata;
        req_valid_i    = 1'b1;
        @(posedge clk);
        #1 req_valid_i = 1'b0;
        t_lat = 0; t_nw = 0; t_nr = 0; t_rdata = '0; t_err = 1'b0;
        t_waddr = '0; t_wdata = '0; t_raddr = '0;
        done = 1'b0;
        for (int c = 1; c <= 8 && !done; c++) begin
            @(negedge clk);
            if (ram_ren_o) begin t_nr++; t_raddr = 32'(ram_r_addr_o); end
            if (ram_wen_o) begin t_nw++; t_waddr = 32'(ram_w_addr_o); t_wdata = ram_w_data_o; end
            if (resp_valid_o) begin
                t_lat = c; t_rdata = resp_rdata_o; t_err = resp_err_o; done = 1'b1;
            end
        end
        if (!done) check("resp_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        bit wen_seen;
        #12;
        check("rst_ready",  {31'b0, req_ready_o},  32'd1);
        check("rst_rvalid", {31'b0, resp_valid_o}, 32'd0);
        check("rst_err",    {31'b0, resp_err_o},   32'd0);
        check("rst_rdata",  resp_rdata_o,          32'd0);
        check("rst_strobes", {30'b0, ram_wen_o, ram_ren_o}, 32'd0);
        check("rst_addrs",  {8'b0, ram_w_addr_o, ram_r_addr_o}, 32'd0);
        check("rst_wdata",  ram_w_data_o,          32'd0);
        @(negedge clk); rst = 1'b0;

        // 1: word store then word load
        do_req(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF);
        check("t1_st_lat", t_lat, 1);
        check("t1_st_nw", t_nw, 1);
        check("t1_st_waddr", t_waddr, 32'd4);
        check("t1_st_wdata", t_wdata, 32'hDEADBEEF);
        check("t1_st_err", {31'b0, t_err}, 32'd0);
        do_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
        check("t1_ld_lat", t_lat, 2);
        check("t1_ld_nr", t_nr, 1);
        check("t1_ld_raddr", t_raddr, 32'd4);
        check("t1_ld_rdata", t_rdata, 32'hDEADBEEF);

        // 2: byte RMW and signed/unsigned byte loads
        do_req(1'b1, 2'b10, 1'b0, 32'h20, 32'h11223344);
        do_req(1'b1, 2'b00, 1'b0, 32'h22, 32'hFFFFFFAA);
        check("t2_rmw_lat", t_lat, 2);
        check("t2_rmw_nr", t_nr, 1);
        check("t2_rmw_waddr", t_waddr, 32'd8);
        check("t2_rmw_wdata", t_wdata, 32'h11AA3344);
        do_req(1'b0, 2'b00, 1'b0, 32'h22, 32'h0);
        check("t2_lb_signed", t_rdata, 32'hFFFFFFAA);
        do_req(1'b0, 2'b00, 1'b1, 32'h22, 32'h0);
        check("t2_lb_unsigned", t_rdata, 32'h000000AA);
        do_req(1'b0, 2'b00, 1'b1, 32'h23, 32'h0);
        check("t2_lb_lane3", t_rdata, 32'h00000011);

        // 3: half store into the upper lanes, then half loads
        do_req(1'b1, 2'b01, 1'b0, 32'h32, 32'h00008001);
        check("t3_sh_wdata", t_wdata, 32'h80010000);
        do_req(1'b0, 2'b01, 1'b0, 32'h32, 32'h0);
        check("t3_lh_signed", t_rdata, 32'hFFFF8001);
        do_req(1'b0, 2'b01, 1'b1, 32'h32, 32'h0);
        check("t3_lh_unsigned", t_rdata, 32'h00008001);

        // 4: misaligned half/word loads
        do_req(1'b1, 2'b01, 1'b0, 32'h30, 32'h00001234);
        check("t4_sh_lo_wdata", t_wdata, 32'h80011234);
        do_req(1'b0, 2'b01, 1'b0, 32'h31, 32'h0);
`ifdef RAM_ACC_MISALIGN_TRAP_EN
        check("t4_lh_mis_err", {31'b0, t_err}, 32'd1);
        check("t4_lh_mis_nr", t_nr, 0);
        check("t4_lh_mis_rdata", t_rdata, 32'd0);
`else
        check("t4_lh_mis_err", {31'b0, t_err}, 32'd0);
        check("t4_lh_mis_rdata", t_rdata, 32'h00001234);
`endif
        do_req(1'b0, 2'b10, 1'b0, 32'h13, 32'h0);
`ifdef RAM_ACC_MISALIGN_TRAP_EN
        check("t4_lw_mis_err", {31'b0, t_err}, 32'd1);
`else
        check("t4_lw_mis_rdata", t_rdata, 32'hDEADBEEF);
`endif

        // 5: illegal size, out of range, top word in range
        do_req(1'b0, 2'b11, 1'b0, 32'h0, 32'h0);
        check("t5_size_err", {31'b0, t_err}, 32'd1);
        check("t5_size_lat", t_lat, 1);
        check("t5_size_strobes", t_nr + t_nw, 0);
        check("t5_size_rdata", t_rdata, 32'd0);
        do_req(1'b1, 2'b10, 1'b0, 32'h4000, 32'hCAFEF00D);
        check("t5_oor_err", {31'b0, t_err}, 32'd1);
        check("t5_oor_strobes", t_nr + t_nw, 0);
        check("t5_mem0_kept", mem[0], 32'd0);
        do_req(1'b1, 2'b10, 1'b0, 32'h3FFC, 32'hA5A55A5A);
        check("t5_top_waddr", t_waddr, 32'hFFF);
        check("t5_top_err", {31'b0, t_err}, 32'd0);
        do_req(1'b0, 2'b10, 1'b0, 32'h3FFC, 32'h0);
        check("t5_top_rdata", t_rdata, 32'hA5A55A5A);

        // 6: reset during RMW_RD abandons the write
        @(negedge clk);
        req_we_i = 1'b1; req_size_i = 2'b00; req_unsigned_i = 1'b0;
        req_addr_i = 32'h10; req_wdata_i = 32'h55; req_valid_i = 1'b1;
        @(posedge clk);
        #1 req_valid_i = 1'b0;
        @(negedge clk);
        check("t6_in_rmw_rd", {30'b0, ram_ren_o, req_ready_o}, 32'd2);
        rst = 1'b1;
        #1;
        check("t6_rst_strobes", {30'b0, ram_wen_o, ram_ren_o}, 32'd0);
        check("t6_rst_rvalid", {31'b0, resp_valid_o}, 32'd0);
        check("t6_rst_addrs", {8'b0, ram_w_addr_o, ram_r_addr_o}, 32'd0);
        check("t6_rst_ready", {31'b0, req_ready_o}, 32'd1);
        wen_seen = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (ram_wen_o) wen_seen = 1'b1;
            if (c == 1) rst = 1'b0;
        end
        check("t6_no_wen", {31'b0, wen_seen}, 32'd0);
        do_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
        check("t6_word_kept", t_rdata, 32'hDEADBEEF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
